// File: rtl/periodic_byte_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periodic_link_pkg
// Purpose  : Shared definitions for the periodic byte link (TX and RX sides).
// Revision : 1.0 - initial release
// ============================================================================
package periodic_link_pkg;

  typedef enum logic [0:0] {
    S0 = 1'b0,  // WAIT
    S1 = 1'b1   // SAMPLE
  } star_t;

  localparam int ADDR_W          = 4;
  localparam int DATA_W          = 8;
  localparam int N_REGS          = 16;
  localparam int CNT_W           = 5;
  localparam int DEFAULT_PERIODI = 10;

endpackage : periodic_link_pkg
`default_nettype wire

// File: rtl/periodic_byte_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : periodic_byte_receiver_if
// Purpose  : Link input buses plus register-file read/status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface periodic_byte_receiver_if;
  import periodic_link_pkg::*;

  logic [ADDR_W-1:0] a3_a0;
  logic [DATA_W-1:0] z7_z0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [N_REGS-1:0] valid;
  logic [7:0]        wr_count;
  logic              new_p;

  modport master (
    output a3_a0, z7_z0, rd_addr,
    input  rd_data, valid, wr_count, new_p
  );

  modport slave (
    input  a3_a0, z7_z0, rd_addr,
    output rd_data, valid, wr_count, new_p
  );

endinterface : periodic_byte_receiver_if
`default_nettype wire

// File: rtl/periodic_byte_receiver_reg_file16x8.sv
`default_nettype none
// ============================================================================
// Module   : reg_file16x8
// Purpose  : 16x8 register file, sync write, async read, sticky valid flags.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file16x8
  import periodic_link_pkg::*;
(
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [ADDR_W-1:0] raddr_i,
  output logic      [DATA_W-1:0] rdata_o,
  output logic      [N_REGS-1:0] valid_o
);

  logic [DATA_W-1:0] mem_q [N_REGS];
  logic [N_REGS-1:0] valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i]   <= wdata_i;
      valid_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign valid_o = valid_q;

endmodule : reg_file16x8
`default_nettype wire

// File: rtl/periodic_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : periodic_byte_receiver
// Purpose  : Strobeless periodic byte-link receiver storing into a 16x8 file.
//            Optional macro DUPLICATE_FILTER_EN drops repeated {addr,data}.
// Revision : 1.0 - initial release
// ============================================================================
module periodic_byte_receiver
  import periodic_link_pkg::*;
#(
  parameter int PERIODI = DEFAULT_PERIODI,
  parameter int OFFSET  = 5
)(
  input wire logic                 clock,
  input wire logic                 reset,
  periodic_byte_receiver_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_count_init   = CNT_W'(PERIODI + OFFSET);
  localparam logic [CNT_W-1:0] c_count_reload = CNT_W'(PERIODI);

  star_t            star_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       wr_count_q;
  logic [7:0]       wr_count_d;
  logic             new_p_q;
  logic             store_d;

`ifdef DUPLICATE_FILTER_EN
  logic [ADDR_W+DATA_W-1:0] prev_q;

  // The copy updates on every sample, duplicates included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if (star_q == S1) begin
      prev_q <= {bus.a3_a0, bus.z7_z0};
    end
  end

  assign store_d = (star_q == S1) && ({bus.a3_a0, bus.z7_z0} != prev_q);
`else
  assign store_d = (star_q == S1);
`endif

  assign wr_count_d = wr_count_q + 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      star_q     <= S0;
      count_q    <= c_count_init;
      wr_count_q <= '0;
      new_p_q    <= 1'b0;
    end else begin
      case (star_q)
        S0: begin
          count_q <= count_q - CNT_W'(1);
          new_p_q <= 1'b0;
          if (count_q == CNT_W'(2)) begin
            star_q <= S1;
          end
        end
        S1: begin
          if (store_d) begin
            wr_count_q <= wr_count_d;
          end
          new_p_q <= store_d;
          count_q <= c_count_reload;
          star_q  <= S0;
        end
        default: begin
          star_q <= S0;
        end
      endcase
    end
  end

  reg_file16x8 u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .we_i    (store_d),
    .waddr_i (bus.a3_a0),
    .wdata_i (bus.z7_z0),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data),
    .valid_o (bus.valid)
  );

  assign bus.wr_count = wr_count_q;
  assign bus.new_p    = new_p_q;

endmodule : periodic_byte_receiver
`default_nettype wire

// File: tb/tb_periodic_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_periodic_byte_receiver
// Purpose  : Directed self-checking bench for periodic_byte_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_periodic_byte_receiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  periodic_byte_receiver_if bus ();

  periodic_byte_receiver #(.PERIODI(10), .OFFSET(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // After release, the next rising edge is edge 1.
  task automatic reset_and_release();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.a3_a0 = 4'd0; bus.z7_z0 = 8'h00; bus.rd_addr = 4'd0;
    reset = 1'b1;
    step(2);
    checks++; if (bus.valid !== 16'h0000) begin errors++; $display("FAIL reset_valid: got %h want 0000", bus.valid); end
    checks++; if (bus.wr_count !== 8'h00) begin errors++; $display("FAIL reset_wr_count: got %h want 00", bus.wr_count); end
    checks++; if (bus.new_p !== 1'b0) begin errors++; $display("FAIL reset_new_p: got %b want 0", bus.new_p); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
  endtask

  task automatic test_first_store();
    bus.a3_a0 = 4'd3; bus.z7_z0 = 8'hA5; bus.rd_addr = 4'd3;
    reset_and_release();
    step(14);
    checks++; if (bus.valid !== 16'h0000) begin errors++; $display("FAIL first_e14_valid: got %h want 0000", bus.valid); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL first_e14_data: got %h want 00", bus.rd_data); end
    step(1);
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL first_e15_data: got %h want a5", bus.rd_data); end
    checks++; if (bus.valid !== 16'h0008) begin errors++; $display("FAIL first_e15_valid: got %h want 0008", bus.valid); end
    checks++; if (bus.wr_count !== 8'h01) begin errors++; $display("FAIL first_e15_count: got %h want 01", bus.wr_count); end
    checks++; if (bus.new_p !== 1'b1) begin errors++; $display("FAIL first_e15_new_p: got %b want 1", bus.new_p); end
    step(1);
    checks++; if (bus.new_p !== 1'b0) begin errors++; $display("FAIL first_e16_new_p: got %b want 0", bus.new_p); end
  endtask

  task automatic test_consecutive_windows();
    bus.a3_a0 = 4'd1; bus.z7_z0 = 8'h11; bus.rd_addr = 4'd1;
    reset_and_release();
    step(15);
    checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL win_e15_data: got %h want 11", bus.rd_data); end
    bus.z7_z0 = 8'h22;
    step(9);
    checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL win_e24_data: got %h want 11", bus.rd_data); end
    step(1);
    checks++; if (bus.rd_data !== 8'h22) begin errors++; $display("FAIL win_e25_data: got %h want 22", bus.rd_data); end
    bus.z7_z0 = 8'h33;
    step(10);
    checks++; if (bus.rd_data !== 8'h33) begin errors++; $display("FAIL win_e35_data: got %h want 33", bus.rd_data); end
    checks++; if (bus.wr_count !== 8'h03) begin errors++; $display("FAIL win_e35_count: got %h want 03", bus.wr_count); end
    checks++; if (bus.valid !== 16'h0002) begin errors++; $display("FAIL win_e35_valid: got %h want 0002", bus.valid); end
  endtask

  task automatic test_mid_reset();
    bus.a3_a0 = 4'd2; bus.z7_z0 = 8'h44; bus.rd_addr = 4'd2;
    reset_and_release();
    step(15);
    checks++; if (bus.new_p !== 1'b1) begin errors++; $display("FAIL mid_e15_new_p: got %b want 1", bus.new_p); end
    step(7);
    reset = 1'b1;
    #1;
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL mid_async_data: got %h want 00", bus.rd_data); end
    checks++; if (bus.valid !== 16'h0000) begin errors++; $display("FAIL mid_async_valid: got %h want 0000", bus.valid); end
    checks++; if (bus.wr_count !== 8'h00) begin errors++; $display("FAIL mid_async_count: got %h want 00", bus.wr_count); end
    @(negedge clock);
    reset = 1'b0;
    step(14);
    checks++; if (bus.wr_count !== 8'h00) begin errors++; $display("FAIL mid_e14_count: got %h want 00", bus.wr_count); end
    step(1);
    checks++; if (bus.wr_count !== 8'h01) begin errors++; $display("FAIL mid_e15_count: got %h want 01", bus.wr_count); end
    checks++; if (bus.rd_data !== 8'h44) begin errors++; $display("FAIL mid_e15_data: got %h want 44", bus.rd_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    reset_and_release();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i + 1);
      bus.a3_a0 = 4'(i);
      bus.z7_z0 = v;
      step((i == 0) ? 15 : 10);
      if (i == 254) begin
        checks++; if (bus.wr_count !== 8'hFF) begin errors++; $display("FAIL wrap_255_count: got %h want ff", bus.wr_count); end
      end
    end
    checks++; if (bus.wr_count !== 8'h00) begin errors++; $display("FAIL wrap_count: got %h want 00", bus.wr_count); end
    checks++; if (bus.valid !== 16'hFFFF) begin errors++; $display("FAIL wrap_valid: got %h want ffff", bus.valid); end
    bus.rd_addr = 4'd14;
    #1;
    checks++; if (bus.rd_data !== 8'hFF) begin errors++; $display("FAIL wrap_mem14: got %h want ff", bus.rd_data); end
  endtask

  task automatic test_read_during_write();
    bus.a3_a0 = 4'd7; bus.z7_z0 = 8'h10; bus.rd_addr = 4'd7;
    reset_and_release();
    step(15);
    bus.z7_z0 = 8'h5C;
    step(9);
    checks++; if (bus.rd_data !== 8'h10) begin errors++; $display("FAIL rdw_before: got %h want 10", bus.rd_data); end
    step(1);
    checks++; if (bus.rd_data !== 8'h5C) begin errors++; $display("FAIL rdw_after: got %h want 5c", bus.rd_data); end
    checks++; if (bus.valid !== 16'h0080) begin errors++; $display("FAIL rdw_valid: got %h want 0080", bus.valid); end
    checks++; if (bus.wr_count !== 8'h02) begin errors++; $display("FAIL rdw_count: got %h want 02", bus.wr_count); end
  endtask

`ifdef DUPLICATE_FILTER_EN
  task automatic test_duplicate_filter();
    bus.a3_a0 = 4'd4; bus.z7_z0 = 8'h77; bus.rd_addr = 4'd4;
    reset_and_release();
    step(15);
    checks++; if (bus.wr_count !== 8'h01) begin errors++; $display("FAIL dup_w1_count: got %h want 01", bus.wr_count); end
    checks++; if (bus.new_p !== 1'b1) begin errors++; $display("FAIL dup_w1_new_p: got %b want 1", bus.new_p); end
    step(10);
    checks++; if (bus.wr_count !== 8'h01) begin errors++; $display("FAIL dup_w2_count: got %h want 01", bus.wr_count); end
    checks++; if (bus.new_p !== 1'b0) begin errors++; $display("FAIL dup_w2_new_p: got %b want 0", bus.new_p); end
    bus.z7_z0 = 8'h78;
    step(10);
    checks++; if (bus.wr_count !== 8'h02) begin errors++; $display("FAIL dup_w3_count: got %h want 02", bus.wr_count); end
    checks++; if (bus.rd_data !== 8'h78) begin errors++; $display("FAIL dup_w3_data: got %h want 78", bus.rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_store();
    test_consecutive_windows();
    test_mid_reset();
    test_wrap();
    test_read_during_write();
`ifdef DUPLICATE_FILTER_EN
    test_duplicate_filter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_periodic_byte_receiver
`default_nettype wire
